// File: rtl/counter_ud_if.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_if
//  Description : Bus bundle for the counter_ud up/down counter.
//                The master drives the controls (load_en, load, down).
//                The slave (the counter) returns count and rollover.
//                Clock and reset are not part of this bundle; they are
//                plain ports on the counter.
//  Signals     : load_en  - preload strobe
//                load     - preload value, WIDTH bits
//                down     - direction, 1 = decrement, 0 = increment
//                count    - registered counter value, WIDTH bits
//                rollover - registered one-cycle wrap-around pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface cnt_if #(
    parameter int WIDTH = 4
);
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             down;
    logic [WIDTH-1:0] count;
    logic             rollover;

    modport master (
        output load_en,
        output load,
        output down,
        input  count,
        input  rollover
    );

    modport slave (
        input  load_en,
        input  load,
        input  down,
        output count,
        output rollover
    );
endinterface : cnt_if
`default_nettype wire

// File: rtl/counter_ud.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ud
//  Description : Loadable up/down binary counter with a registered
//                wrap-around (rollover) pulse. The counter advances one
//                step on every rising clock edge. It counts up or down,
//                as selected by 'down'. A synchronous load takes
//                priority over counting. The counter never idles: it
//                holds its value only when a load writes back the
//                current value.
//  Ports       : clk  - clock, rising-edge active
//                rstn - synchronous active-low reset
//                bus  - cnt_if slave modport
//                       in : load_en, load, down
//                       out: count, rollover
//  Parameters  : WIDTH - counter width in bits (>= 1). It must match the
//                        WIDTH of the connected cnt_if instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_ud #(
    parameter int WIDTH = 4
) (
    input  wire logic clk,
    input  wire logic rstn,
    cnt_if.slave      bus
);

    localparam logic [WIDTH-1:0] c_zero     = '0;
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_all_ones = '1;

    logic [WIDTH-1:0] r_count;
    logic             r_rollover;

    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap;

    // Next-state selection: a load wins over counting.
    // A wrap is flagged only when the counter itself crosses the
    // all-ones/zero boundary. A load of either boundary value is not a
    // wrap.
    always_comb begin
        w_count_next = r_count;
        w_wrap       = 1'b0;
        if (bus.load_en) begin
            w_count_next = bus.load;
        end else if (bus.down) begin
            w_count_next = r_count - c_one;
            w_wrap       = (r_count == c_zero);
        end else begin
            w_count_next = r_count + c_one;
            w_wrap       = (r_count == c_all_ones);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count    <= c_zero;
            r_rollover <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_rollover <= w_wrap;
        end
    end

    // Both outputs come straight from flops. No input reaches an output
    // combinationally.
    assign bus.count    = r_count;
    assign bus.rollover = r_rollover;

endmodule : counter_ud
`default_nettype wire

// File: tb/tb_counter_ud.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_ud
//  Description : Self-checking bench for counter_ud (WIDTH = 4).
//                Directed vectors carry hand-computed expectations.
//                An integer-arithmetic reference model is compared
//                against count/rollover on every falling edge once reset
//                has been seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ud;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic clk;
    logic rstn;

    int checks;
    int errors;

    cnt_if #(.WIDTH(W)) bus ();

    counter_ud #(.WIDTH(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: plain modular arithmetic on an integer.
    // ------------------------------------------------------------------
    int m_count;
    bit m_roll;
    bit m_valid;

    initial begin
        m_count = 0;
        m_roll  = 1'b0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (!rstn) begin
            m_count = 0;
            m_roll  = 1'b0;
            m_valid = 1'b1;
        end else if (bus.load_en) begin
            m_count = int'(bus.load);
            m_roll  = 1'b0;
        end else if (bus.down) begin
            m_roll  = (m_count == 0);
            m_count = (m_count + MOD - 1) % MOD;
        end else begin
            m_roll  = (m_count + 1 == MOD);
            m_count = (m_count + 1) % MOD;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_count", int'(bus.count), m_count);
            chk("model_rollover", int'(bus.rollover), int'(m_roll));
        end
    end

    // One rising edge, then settle on the falling edge for checks/drives.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input int c, input int r);
        chk({name, "_count"}, int'(bus.count), c);
        chk({name, "_rollover"}, int'(bus.rollover), r);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn        = 1'b0;
        bus.load_en = 1'b0;
        bus.load    = '0;
        bus.down    = 1'b0;

        // Initial reset.
        step();
        expect_out("init_reset", 0, 0);

        // Preload 0x9, then hold reset for 5 clocks.
        rstn        = 1'b1;
        bus.load_en = 1'b1;
        bus.load    = 4'h9;
        step();
        expect_out("preload9", 9, 0);
        rstn        = 1'b0;
        bus.load_en = 1'b0;
        step();
        expect_out("reset_first_edge", 0, 0);
        for (int i = 0; i < 4; i++) step();
        expect_out("reset_held", 0, 0);

        // Up count from 0 for 16 clocks.
        rstn        = 1'b1;
        bus.load_en = 1'b0;
        bus.down    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            expect_out($sformatf("up%0d", i), (i + 1) % 16, (i == 15) ? 1 : 0);
        end

        // Down count from a load of 0x2.
        bus.load_en = 1'b1;
        bus.load    = 4'h2;
        step();
        expect_out("load2", 2, 0);
        bus.load_en = 1'b0;
        bus.down    = 1'b1;
        step(); expect_out("down_1", 4'h1, 0);
        step(); expect_out("down_0", 4'h0, 0);
        step(); expect_out("down_F", 4'hF, 1);
        chk("model_pin_roll", int'(m_roll), 1);
        step(); expect_out("down_E", 4'hE, 0);

        // Load priority over down.
        bus.load_en = 1'b1;
        bus.load    = 4'h7;
        step();
        expect_out("load7", 7, 0);
        bus.load    = 4'hC;
        bus.down    = 1'b1;
        step();
        expect_out("load_prio", 4'hC, 0);
        chk("model_pin_C", m_count, 4'hC);
        bus.load_en = 1'b0;
        step();
        expect_out("after_load_down", 4'hB, 0);

        // Loading the current value holds the counter.
        bus.load_en = 1'b1;
        bus.load    = 4'hB;
        step();
        expect_out("load_hold", 4'hB, 0);

        // Boundary loads: neither raises rollover; the next count wraps.
        bus.load    = 4'hF;
        bus.down    = 1'b0;
        step();
        expect_out("loadF", 4'hF, 0);
        bus.load_en = 1'b0;
        step();
        expect_out("wrap_up", 4'h0, 1);
        chk("model_pin_zero", m_count, 0);
        bus.load_en = 1'b1;
        bus.load    = 4'h0;
        step();
        expect_out("load0", 4'h0, 0);
        bus.load_en = 1'b0;
        bus.down    = 1'b1;
        step();
        expect_out("wrap_down", 4'hF, 1);
        bus.down    = 1'b0;
        step();
        expect_out("dir_change", 4'h0, 1);

        // Random stimulus at off-edge times, with two mid-run resets.
        for (int n = 0; n < 400; n++) begin
            int unsigned d;
            if (n == 150 || n == 300) begin
                @(negedge clk);
                rstn = 1'b0;
                step();
                expect_out($sformatf("midrun_reset%0d", n), 0, 0);
                rstn = 1'b1;
            end
            d = $urandom_range(30, 1);
            #(d);
            if (($time % 10) == 5) #1;
            bus.load_en = ($urandom_range(3, 0) == 0);
            bus.load    = W'($urandom);
            bus.down    = 1'($urandom_range(1, 0));
        end
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_ud
`default_nettype wire
